// File: rtl/spi_xip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xip_pkg
//  Purpose  : Shared definitions for the SPI XIP read sequencer: SPI master
//             register offsets, default flash read opcode, FSM encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_xip_pkg;

    // SPI master APB register offsets (TX_0 and RX_0 share offset 0x00)
    localparam logic [4:0] SPI_TX_0 = 5'h00;
    localparam logic [4:0] SPI_TX_1 = 5'h04;
    localparam logic [4:0] SPI_CTRL = 5'h10;

    // Standard serial-flash "read data" opcode
    localparam logic [7:0] DEFAULT_READ_CMD = 8'h03;

    // Sequencer states, one per APB access plus the idle and response states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_TX1  = 3'd1,
        ST_WR_TX0  = 3'd2,
        ST_WR_CTRL = 3'd3,
        ST_POLL    = 3'd4,
        ST_RD_RX   = 3'd5,
        ST_RESP    = 3'd6
    } xip_state_t;

    // Phases of a single APB transfer
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } apb_phase_t;

endpackage : spi_xip_pkg
`default_nettype wire

// File: rtl/spi_xip_apb_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xip_apb_if
//  Purpose  : Single-access APB master engine. A start pulse while idle
//             launches one SETUP/ACCESS transfer; done flags the cycle in
//             which the slave completes it, with rdata/err valid alongside.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xip_apb_if
    import spi_xip_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // request side
    input  logic        start,
    input  logic [4:0]  addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    // APB master port
    output logic [4:0]  m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr
);

    apb_phase_t phase;

    // Completion is the ACCESS cycle in which the slave raises pready;
    // read data and error are only meaningful together with done.
    assign busy  = (phase != PH_IDLE);
    assign done  = (phase == PH_ACCESS) && m_pready;
    assign rdata = m_prdata;
    assign err   = m_pslverr;

    // Transfer phase sequencing; address/control/data are captured at start
    // and held unchanged through SETUP and ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= PH_IDLE;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        m_psel    <= 1'b1;
                        m_penable <= 1'b0;
                        m_paddr   <= addr;
                        m_pwrite  <= write;
                        m_pwdata  <= wdata;
                        phase     <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    m_penable <= 1'b1;
                    phase     <= PH_ACCESS;
                end
                PH_ACCESS: begin
                    if (m_pready) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        phase     <= PH_IDLE;
                    end
                end
                default: begin
                    m_psel    <= 1'b0;
                    m_penable <= 1'b0;
                    phase     <= PH_IDLE;
                end
            endcase
        end
    end

endmodule : spi_xip_apb_if
`default_nettype wire

// File: rtl/spi_xip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xip_ctrl
//  Purpose  : Read-only XIP sequencer. Converts one 24-bit flash word read
//             into the SPI master register sequence TX_1, TX_0, CTRL(GO),
//             CTRL polling, RX_0 read, and returns the received word.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xip_ctrl
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] CTRL_CFG = 32'h0000_0000,
    parameter int          GO_BIT   = 8,
    parameter int          POLL_MAX = 1023,
    parameter logic [7:0]  READ_CMD = DEFAULT_READ_CMD
)(
    input  logic        clk,
    input  logic        rst,
    // request / response
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    // APB master port to the SPI master
    output logic [4:0]  m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr
);

    localparam int          CNT_W     = $clog2(POLL_MAX + 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);
    localparam logic [31:0] GO_MASK   = 32'(1) << GO_BIT;

    xip_state_t       state;
    logic [23:0]      addr_q;
    logic [CNT_W-1:0] poll_cnt;

    logic        acc_active;
    logic [4:0]  acc_addr;
    logic        acc_write;
    logic [31:0] acc_wdata;
    logic        apb_start;
    logic        apb_busy;
    logic        apb_done;
    logic [31:0] apb_rdata;
    logic        apb_err;

    // Access descriptor for the current state; the engine samples it on start
    always_comb begin
        acc_active = 1'b1;
        acc_addr   = SPI_TX_0;
        acc_write  = 1'b0;
        acc_wdata  = '0;
        case (state)
            ST_WR_TX1: begin
                acc_addr  = SPI_TX_1;
                acc_write = 1'b1;
                acc_wdata = {READ_CMD, addr_q};
            end
            ST_WR_TX0: begin
                acc_addr  = SPI_TX_0;
                acc_write = 1'b1;
            end
            ST_WR_CTRL: begin
                acc_addr  = SPI_CTRL;
                acc_write = 1'b1;
                acc_wdata = CTRL_CFG | GO_MASK;
            end
            ST_POLL:  acc_addr = SPI_CTRL;
            ST_RD_RX: acc_addr = SPI_TX_0;
            default:  acc_active = 1'b0;
        endcase
    end

    // Launch an access whenever an access state is entered or re-entered
    assign apb_start = acc_active && !apb_busy;

    spi_xip_apb_if u_apb (
        .clk       (clk),
        .rst       (rst),
        .start     (apb_start),
        .addr      (acc_addr),
        .write     (acc_write),
        .wdata     (acc_wdata),
        .busy      (apb_busy),
        .done      (apb_done),
        .rdata     (apb_rdata),
        .err       (apb_err),
        .m_paddr   (m_paddr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr)
    );

    // Sequence FSM with address latch, poll counter and response registers.
    // A slave error on any access ends the sequence immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            addr_q     <= '0;
            poll_cnt   <= '0;
        end else if (apb_done && apb_err) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        poll_cnt  <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_WR_TX1;
                    end
                end
                ST_WR_TX1:  if (apb_done) state <= ST_WR_TX0;
                ST_WR_TX0:  if (apb_done) state <= ST_WR_CTRL;
                ST_WR_CTRL: if (apb_done) state <= ST_POLL;
                ST_POLL: begin
                    if (apb_done) begin
                        if (!apb_rdata[GO_BIT]) begin
                            state <= ST_RD_RX;
                        end else if (poll_cnt == POLL_LAST) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                end
                ST_RD_RX: begin
                    if (apb_done) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= apb_rdata;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule : spi_xip_ctrl
`default_nettype wire

// File: tb/tb_spi_xip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_xip_ctrl
//  Purpose  : Self-checking bench for spi_xip_ctrl: APB slave model of the
//             SPI master, protocol monitor, transaction-level expected model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xip_ctrl;

    localparam logic [31:0] TB_CFG  = 32'h0000_3400;
    localparam int          TB_PMAX = 4;

    typedef struct {
        bit        w;
        bit [4:0]  a;
        bit [31:0] d;
    } xact_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [4:0]  m_paddr;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_pwdata;
    logic [31:0] m_prdata = '0;
    logic        m_pready = 1'b0;
    logic        m_pslverr = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int proto_viol = 0;

    // slave model configuration and log
    int          cfg_go = 0;
    int          cfg_err_idx = -1;
    logic [31:0] cfg_rx = '0;
    int          go_seen = 0;
    int          acc_idx = 0;
    int          acc_cyc = 0;
    int          wait_tgt = 1;
    xact_t       log_q[$];
    xact_t       exp_q[$];
    logic [31:0] exp_data;
    logic        exp_err;

    // monitor history
    logic        prev_psel = 0, prev_pen = 0, prev_pready = 0, prev_write = 0;
    logic [4:0]  prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    always #5 clk = ~clk;

    spi_xip_ctrl #(
        .CTRL_CFG (TB_CFG),
        .GO_BIT   (8),
        .POLL_MAX (TB_PMAX),
        .READ_CMD (8'h03)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .m_paddr    (m_paddr),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_pwrite   (m_pwrite),
        .m_pwdata   (m_pwdata),
        .m_prdata   (m_prdata),
        .m_pready   (m_pready),
        .m_pslverr  (m_pslverr)
    );

    // APB protocol monitor and SPI-master slave model, evaluated mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            m_pready = 1'b0; m_pslverr = 1'b0; acc_cyc = 0;
            prev_psel = 0; prev_pen = 0; prev_pready = 0;
        end else begin
            if (m_penable && !m_psel) begin
                proto_viol++; $display("FAIL apb_enable_wo_sel: penable=1 psel=0, required psel=1");
            end
            if (m_psel && m_penable && !prev_pen &&
                !(prev_psel && prev_addr == m_paddr && prev_write == m_pwrite && prev_wdata == m_pwdata)) begin
                proto_viol++; $display("FAIL apb_setup: access addr=%h without matching setup (prev psel=%0d addr=%h)", m_paddr, prev_psel, prev_addr);
            end
            if (m_psel && m_penable && prev_pen &&
                !(prev_addr == m_paddr && prev_write == m_pwrite && prev_wdata == m_pwdata)) begin
                proto_viol++; $display("FAIL apb_stable: addr %h->%h write %0d->%0d, required unchanged", prev_addr, m_paddr, prev_write, m_pwrite);
            end
            if (m_psel && !m_penable && prev_pen && !prev_pready) begin
                proto_viol++; $display("FAIL apb_abandon: new setup before pready, required access held");
            end
            if (req_ready && m_psel) begin
                proto_viol++; $display("FAIL apb_idle_sel: psel=1 while req_ready=1, required psel=0");
            end
            prev_psel = m_psel; prev_pen = m_penable; prev_pready = m_pready;
            prev_addr = m_paddr; prev_write = m_pwrite; prev_wdata = m_pwdata;

            if (m_psel && m_penable) begin
                acc_cyc++;
                if (acc_cyc >= wait_tgt) begin
                    m_pready  = 1'b1;
                    m_pslverr = (acc_idx == cfg_err_idx);
                    if (m_pwrite) m_prdata = $urandom;
                    else if (m_paddr == 5'h10) begin
                        m_prdata = $urandom & ~32'h100;
                        if (go_seen < cfg_go) begin
                            m_prdata = m_prdata | 32'h100;
                            go_seen++;
                        end
                    end else m_prdata = cfg_rx;
                    log_q.push_back('{m_pwrite, m_paddr, m_pwdata});
                    acc_idx++;
                end else begin
                    m_pready = 1'b0; m_pslverr = 1'b0;
                end
            end else begin
                m_pready = 1'b0; m_pslverr = 1'b0; acc_cyc = 0;
                wait_tgt = $urandom_range(1, 3);
            end
        end
    end

    // Expected transaction list and result for one request
    function automatic void build_exp(input logic [23:0] a, input int g, input int e, input logic [31:0] rx);
        int nreads;
        exp_q.delete();
        exp_q.push_back('{1'b1, 5'h04, {8'h03, a}});
        exp_q.push_back('{1'b1, 5'h00, 32'h0});
        exp_q.push_back('{1'b1, 5'h10, TB_CFG | 32'h100});
        nreads = (g >= TB_PMAX) ? TB_PMAX : g + 1;
        for (int i = 0; i < nreads; i++) exp_q.push_back('{1'b0, 5'h10, 32'h0});
        exp_err  = (g >= TB_PMAX);
        exp_data = exp_err ? 32'h0 : rx;
        if (g < TB_PMAX) exp_q.push_back('{1'b0, 5'h00, 32'h0});
        if (e >= 0 && e < exp_q.size()) begin
            while (exp_q.size() > e + 1) void'(exp_q.pop_back());
            exp_err  = 1'b1;
            exp_data = 32'h0;
        end
    endfunction

    function automatic int count_diffs();
        int n = 0;
        if (log_q.size() != exp_q.size()) n++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            if (log_q[i].w != exp_q[i].w || log_q[i].a != exp_q[i].a ||
                (exp_q[i].w && log_q[i].d != exp_q[i].d)) n++;
        return n;
    endfunction

    function automatic int count_ctrl_reads();
        int n = 0;
        foreach (log_q[i]) if (!log_q[i].w && log_q[i].a == 5'h10) n++;
        return n;
    endfunction

    task automatic setup_slave(input int g, input int e, input logic [31:0] rx);
        cfg_go = g; cfg_err_idx = e; cfg_rx = rx;
        go_seen = 0; acc_idx = 0; log_q.delete();
    endtask

    // Issue one request from a negedge; address is scrambled after acceptance
    task automatic send_req(input logic [23:0] a);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_addr = a;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 24'($urandom);
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 2000 && !resp_valid; i++) @(negedge clk);
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic do_request(input logic [23:0] a, input int g, input int e, input logic [31:0] rx);
        setup_slave(g, e, rx);
        build_exp(a, g, e, rx);
        send_req(a);
        wait_resp();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_err} !== 2'b00) $display("FAIL rst_resp: valid/err got %b want 00", {resp_valid, resp_err}); else pass_cnt++;
        total_cnt++; if (resp_data !== 32'h0) $display("FAIL rst_resp_data: got %h want 0", resp_data); else pass_cnt++;
        total_cnt++; if ({m_psel, m_penable, m_pwrite} !== 3'b000) $display("FAIL rst_apb_ctl: got %b want 000", {m_psel, m_penable, m_pwrite}); else pass_cnt++;
        total_cnt++; if ({m_paddr, m_pwdata} !== 37'h0) $display("FAIL rst_apb_bus: addr %h wdata %h want 0", m_paddr, m_pwdata); else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (req_ready !== 1'b1 || m_psel !== 1'b0) $display("FAIL idle_after_rst: req_ready=%b psel=%b want 1/0", req_ready, m_psel); else pass_cnt++;
    endtask

    task automatic test_basic();
        do_request(24'h123456, 3, -1, 32'hDEADBEEF);
        total_cnt++; if (resp_valid !== 1'b1) $display("FAIL basic_timeout: resp_valid=%b want 1", resp_valid); else pass_cnt++;
        total_cnt++; if (count_diffs() !== 0) $display("FAIL basic_seq: %0d diffs, log %0d entries want %0d", count_diffs(), log_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++; if (count_ctrl_reads() !== 4) $display("FAIL basic_polls: got %0d CTRL reads want 4", count_ctrl_reads()); else pass_cnt++;
        total_cnt++; if (resp_data !== 32'hDEADBEEF) $display("FAIL basic_data: got %h want deadbeef", resp_data); else pass_cnt++;
        total_cnt++; if (resp_err !== 1'b0) $display("FAIL basic_err: got %b want 0", resp_err); else pass_cnt++;
        ack();
        total_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL basic_ack: valid=%b ready=%b want 0/1", resp_valid, req_ready); else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_request(24'hABCDEF, 100, -1, 32'h12345678);
        total_cnt++; if (count_ctrl_reads() !== TB_PMAX) $display("FAIL to_polls: got %0d CTRL reads want %0d", count_ctrl_reads(), TB_PMAX); else pass_cnt++;
        total_cnt++; if (count_diffs() !== 0) $display("FAIL to_seq: %0d diffs (log %0d want %0d, no RX read)", count_diffs(), log_q.size(), exp_q.size()); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_err} !== 2'b11 || resp_data !== 32'h0) $display("FAIL to_resp: v/e=%b data=%h want 11/0", {resp_valid, resp_err}, resp_data); else pass_cnt++;
        ack();
    endtask

    task automatic test_pslverr();
        logic [31:0] rx2;
        do_request(24'h55AA55, 0, 2, 32'hCAFEF00D);
        total_cnt++; if (count_diffs() !== 0) $display("FAIL slverr_seq: %0d diffs, log %0d entries want 3", count_diffs(), log_q.size()); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_err} !== 2'b11 || resp_data !== 32'h0) $display("FAIL slverr_resp: v/e=%b data=%h want 11/0", {resp_valid, resp_err}, resp_data); else pass_cnt++;
        ack();
        rx2 = $urandom;
        do_request(24'h000010, 1, -1, rx2);
        total_cnt++; if (count_diffs() !== 0) $display("FAIL slverr_next_seq: %0d diffs", count_diffs()); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_err} !== 2'b10 || resp_data !== rx2) $display("FAIL slverr_next_resp: v/e=%b data=%h want 10/%h", {resp_valid, resp_err}, resp_data, rx2); else pass_cnt++;
        ack();
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            logic [23:0] a;
            logic [31:0] rx;
            int g, e;
            a  = 24'($urandom);
            rx = $urandom;
            g  = $urandom_range(0, 5);
            e  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
            do_request(a, g, e, rx);
            total_cnt++; if (count_diffs() !== 0) $display("FAIL rand_seq[%0d]: %0d diffs g=%0d e=%0d", k, count_diffs(), g, e); else pass_cnt++;
            total_cnt++; if ({resp_valid, resp_err} !== {1'b1, exp_err} || resp_data !== exp_data)
                $display("FAIL rand_resp[%0d]: v/e=%b data=%h want 1%b/%h", k, {resp_valid, resp_err}, resp_data, exp_err, exp_data);
            else pass_cnt++;
            ack();
        end
    endtask

    task automatic test_resp_hold();
        logic [31:0] d0;
        logic        e0;
        int          bad = 0;
        int          n0;
        do_request(24'h0F0F0F, 0, -1, 32'h600DF00D);
        d0 = resp_data; e0 = resp_err; n0 = log_q.size();
        for (int i = 0; i < 10; i++) begin
            req_valid = i[0];
            req_addr  = 24'($urandom);
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== d0 || resp_err !== e0 || req_ready !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        total_cnt++; if (bad !== 0) $display("FAIL hold_stable: %0d unstable cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (d0 !== 32'h600DF00D) $display("FAIL hold_data: got %h want 600df00d", d0); else pass_cnt++;
        total_cnt++; if (log_q.size() !== n0) $display("FAIL hold_ignored: log %0d entries want %0d", log_q.size(), n0); else pass_cnt++;
        ack();
        total_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL hold_release: valid=%b ready=%b want 0/1", resp_valid, req_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int  i;
        setup_slave(50, -1, 32'h0);
        send_req(24'h777777);
        for (i = 0; i < 500 && !(m_psel && m_penable && m_paddr == 5'h10 && !m_pwrite); i++) @(negedge clk);
        total_cnt++; if (i >= 500) $display("FAIL midrst_reach_poll: CTRL read access not reached within %0d cycles", i); else pass_cnt++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if ({m_psel, m_penable, resp_valid, req_ready} !== 4'b0001)
            $display("FAIL midrst_outputs: psel/pen/valid/ready=%b want 0001", {m_psel, m_penable, resp_valid, req_ready});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_request(24'h3C3C3C, 2, -1, 32'hA5A5_5A5A);
        total_cnt++; if (count_diffs() !== 0) $display("FAIL midrst_next_seq: %0d diffs", count_diffs()); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_err} !== 2'b10 || resp_data !== 32'hA5A5_5A5A) $display("FAIL midrst_next_resp: v/e=%b data=%h want 10/a5a55a5a", {resp_valid, resp_err}, resp_data); else pass_cnt++;
        ack();
    endtask

    task automatic test_protocol();
        total_cnt++; if (proto_viol !== 0) $display("FAIL apb_protocol_total: %0d violations want 0", proto_viol); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_pslverr();
        test_random();
        test_resp_hold();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule : tb_spi_xip_ctrl
`default_nettype wire
